// File: rtl/riscv_pipe_pkg.sv
// Shared opcode, instruction-field and state definitions for the pipeline
// hazard controller and its decoder.
package riscv_pipe_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100111;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    FREEZE
  } pipe_state_e;

endpackage

// File: rtl/instr_src_decode.sv
// Combinational decode of the instruction in ID: register indices, which
// sources are actually read, and whether it is a load.
module instr_src_decode
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [31:0]       id_instr,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic              uses_rs1,
  output logic              uses_rs2,
  output logic              is_load
);

  logic [OPC_W-1:0] opc;
  logic             unused_bits;

  always_comb begin
    opc      = id_instr[OPC_LSB +: OPC_W];
    rd       = id_instr[RD_LSB  +: REG_AW];
    rs1      = id_instr[RS1_LSB +: REG_AW];
    rs2      = id_instr[RS2_LSB +: REG_AW];
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_load  = 1'b0;
    case (opc)
      OPC_RTYPE, OPC_STORE, OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_ITYPE: uses_rs1 = 1'b1;
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        is_load  = 1'b1;
      end
      default: ;
    endcase
  end

  assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// taken-branch redirect with IF/ID flush, and freeze on data-memory busy.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_AW       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     id_instr,
  input  logic            id_valid,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            dmem_busy,
  output logic            stall,
  output logic            branch_en,
  output logic [XLEN-1:0] branch_pc,
  output logic            if_id_flush,
  output logic            id_ex_bubble,
  output logic [15:0]     hazard_cnt
);

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              uses_rs1, uses_rs2, is_load;

  instr_src_decode #(.REG_AW(REG_AW)) u_dec (
    .id_instr (id_instr),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_load  (is_load)
  );

  pipe_state_e       state_q, state_d, prior_q, prior_d, eff_state;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic              ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic [15:0]       hcnt_q, hcnt_d;
  logic              load_use, redirect;
  logic              mem_unused;

  assign load_use = ex_ld_q && (ex_rd_q != '0) && id_valid &&
                    ((uses_rs1 && (rs1 == ex_rd_q)) || (uses_rs2 && (rs2 == ex_rd_q)));

  always_comb begin
    state_d      = state_q;
    prior_d      = prior_q;
    fcnt_d       = fcnt_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    ex_ld_d      = ex_ld_q;
    ex_rd_d      = ex_rd_q;
    mem_ld_d     = mem_ld_q;
    mem_rd_d     = mem_rd_q;
    hcnt_d       = hcnt_q;
    stall        = 1'b0;
    branch_en    = 1'b0;
    branch_pc    = '0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    redirect     = 1'b0;
    // A release cycle out of FREEZE behaves as the state that was frozen.
    eff_state    = (state_q == FREEZE) ? prior_q : state_q;

    if (rst) begin
      state_d = state_q;
    end else if (dmem_busy) begin
      stall   = 1'b1;
      state_d = FREEZE;
      if (state_q != FREEZE) prior_d = state_q;
      if (ex_branch_taken) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = ex_branch_target;
      end
    end else begin
      state_d  = eff_state;
      redirect = ex_branch_taken || pend_valid_q;
      if (redirect) begin
        branch_en    = 1'b1;
        branch_pc    = ex_branch_taken ? ex_branch_target : pend_pc_q;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        pend_valid_d = 1'b0;
        fcnt_d       = 3'(FLUSH_CYCLES - 1);
        state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else begin
        if (eff_state == FLUSH) begin
          if_id_flush = 1'b1;
          fcnt_d      = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) state_d = RUN;
        end
        if (load_use) begin
          stall        = 1'b1;
          id_ex_bubble = 1'b1;
          if (hcnt_q != '1) hcnt_d = hcnt_q + 16'd1;
        end
      end
      ex_ld_d  = id_valid && is_load && !id_ex_bubble && !if_id_flush;
      ex_rd_d  = rd;
      mem_ld_d = ex_ld_q;
      mem_rd_d = ex_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      prior_q      <= RUN;
      fcnt_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      ex_ld_q      <= 1'b0;
      ex_rd_q      <= '0;
      mem_ld_q     <= 1'b0;
      mem_rd_q     <= '0;
      hcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      prior_q      <= prior_d;
      fcnt_q       <= fcnt_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      ex_ld_q      <= ex_ld_d;
      ex_rd_q      <= ex_rd_d;
      mem_ld_q     <= mem_ld_d;
      mem_rd_q     <= mem_rd_d;
      hcnt_q       <= hcnt_d;
    end
  end

  assign hazard_cnt = rst ? '0 : hcnt_q;
  assign mem_unused = ^{mem_ld_q, mem_rd_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a per-cycle behavioural
// reference and a few literal spot checks.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;
  localparam logic [6:0] T_RTYPE  = 7'b0110011;
  localparam logic [6:0] T_ITYPE  = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_instr = '0;
  logic        id_valid = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic [63:0] ex_branch_target = '0;
  logic        dmem_busy = 1'b0;
  logic        stall, branch_en, if_id_flush, id_ex_bubble;
  logic [63:0] branch_pc;
  logic [15:0] hazard_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.XLEN(64), .FLUSH_CYCLES(FC), .REG_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_instr         (id_instr),
    .id_valid         (id_valid),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .dmem_busy        (dmem_busy),
    .stall            (stall),
    .branch_en        (branch_en),
    .branch_pc        (branch_pc),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .hazard_cnt       (hazard_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tiny fetch unit so PC hold/redirect can be observed.
  logic [63:0] tb_pc = '0;
  always @(posedge clk) begin
    if (rst)            tb_pc <= '0;
    else if (branch_en) tb_pc <= branch_pc;
    else if (!stall)    tb_pc <= tb_pc + 64'd4;
  end

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, opc};
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [6:0] opc;
    opc = ins[6:0];
    if (opc == T_RTYPE || opc == T_STORE || opc == T_BRANCH)
      return (ins[19:15] == r) || (ins[24:20] == r);
    if (opc == T_ITYPE || opc == T_LOAD)
      return ins[19:15] == r;
    return 1'b0;
  endfunction

  // Reference: the loaded-register slot in EX, flush cycles still owed,
  // a branch waiting for memory, and the stall tally.
  bit          m_pend_v = 1'b0;
  logic [63:0] m_pend_pc = '0;
  int          m_flush_left = 0;
  bit          m_ex_load = 1'b0;
  logic [4:0]  m_ex_rd = '0;
  int          m_hcnt = 0;
  bit          e_stall, e_ben, e_flush, e_bub, lu, redir;
  logic [63:0] e_pc;

  always @(negedge clk) begin
    e_stall = 0; e_ben = 0; e_flush = 0; e_bub = 0; e_pc = '0;
    lu = m_ex_load && (m_ex_rd != 0) && id_valid && reads_reg(id_instr, m_ex_rd);
    redir = ex_branch_taken || m_pend_v;
    if (!rst) begin
      if (dmem_busy) e_stall = 1;
      else if (redir) begin
        e_ben = 1; e_flush = 1; e_bub = 1;
        e_pc = ex_branch_taken ? ex_branch_target : m_pend_pc;
      end else begin
        e_flush = m_flush_left > 0;
        e_stall = lu;
        e_bub   = lu;
      end
    end
    check("stall", 64'(stall), 64'(e_stall));
    check("branch_en", 64'(branch_en), 64'(e_ben));
    check("branch_pc", branch_pc, e_pc);
    check("if_id_flush", 64'(if_id_flush), 64'(e_flush));
    check("id_ex_bubble", 64'(id_ex_bubble), 64'(e_bub));
    check("hazard_cnt", 64'(hazard_cnt), rst ? 64'd0 : 64'(m_hcnt));
    if (rst) begin
      m_pend_v = 0; m_flush_left = 0; m_ex_load = 0; m_ex_rd = '0; m_hcnt = 0;
    end else if (dmem_busy) begin
      if (ex_branch_taken) begin m_pend_v = 1; m_pend_pc = ex_branch_target; end
    end else begin
      if (redir) begin
        m_pend_v = 0;
        m_flush_left = FC - 1;
      end else begin
        if (m_flush_left > 0) m_flush_left--;
        if (lu && m_hcnt < 65535) m_hcnt++;
      end
      m_ex_load = id_valid && (id_instr[6:0] == T_LOAD) && !e_bub && !e_flush;
      m_ex_rd   = id_instr[11:7];
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic tk,
                       input logic [63:0] tgt, input logic busy, input logic r);
    id_valid = v; id_instr = ins; ex_branch_taken = tk;
    ex_branch_target = tgt; dmem_busy = busy; rst = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, '0, 0, '0, 0, 0);
  endtask

  logic [31:0] use_ins [6];
  logic [4:0]  ld_reg  [6];
  logic        use_v   [6];
  logic        want    [6];
  logic [63:0] pc_before;

  initial begin
    drive(0, '0, 0, '0, 0, 1);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_cnt", 64'(hazard_cnt), 64'd0);
    tick(); tick();
    idle(); tick();

    // x0 destination never hazards
    drive(1, mk(T_LOAD, 5'd0, 5'd1, 5'd0), 0, '0, 0, 0); tick();
    drive(1, mk(T_RTYPE, 5'd9, 5'd0, 5'd6), 0, '0, 0, 0);
    check("x0_nostall", 64'(stall), 64'd0); tick();
    idle(); check("x0_cnt", 64'(hazard_cnt), 64'd0); tick();

    // basic load-use: one stall cycle, PC held
    drive(1, mk(T_LOAD, 5'd5, 5'd1, 5'd0), 0, '0, 0, 0); tick();
    drive(1, mk(T_RTYPE, 5'd9, 5'd5, 5'd6), 0, '0, 0, 0);
    check("lu_stall", 64'(stall), 64'd1);
    check("lu_bubble", 64'(id_ex_bubble), 64'd1);
    pc_before = tb_pc; tick();
    check("lu_pc_hold", tb_pc, pc_before);
    drive(1, mk(T_RTYPE, 5'd9, 5'd5, 5'd6), 0, '0, 0, 0);
    check("lu_once", 64'(stall), 64'd0);
    check("lu_cnt", 64'(hazard_cnt), 64'd1); tick();
    idle(); tick();

    // source-usage decode per opcode
    ld_reg[0] = 5'd7;  use_ins[0] = mk(T_STORE, 5'd0, 5'd1, 5'd7);   use_v[0] = 1; want[0] = 1;
    ld_reg[1] = 5'd8;  use_ins[1] = mk(T_ITYPE, 5'd2, 5'd8, 5'd0);   use_v[1] = 1; want[1] = 1;
    ld_reg[2] = 5'd3;  use_ins[2] = mk(T_LUI, 5'd2, 5'd3, 5'd3);     use_v[2] = 1; want[2] = 0;
    ld_reg[3] = 5'd4;  use_ins[3] = mk(T_ITYPE, 5'd2, 5'd1, 5'd4);   use_v[3] = 1; want[3] = 0;
    ld_reg[4] = 5'd12; use_ins[4] = mk(T_BRANCH, 5'd0, 5'd2, 5'd12); use_v[4] = 1; want[4] = 1;
    ld_reg[5] = 5'd13; use_ins[5] = mk(T_RTYPE, 5'd2, 5'd13, 5'd1);  use_v[5] = 0; want[5] = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, mk(T_LOAD, ld_reg[i], 5'd1, 5'd0), 0, '0, 0, 0); tick();
      drive(use_v[i], use_ins[i], 0, '0, 0, 0);
      check($sformatf("dec_%0d", i), 64'(stall), 64'(want[i])); tick();
      idle(); tick();
    end
    check("dec_cnt", 64'(hazard_cnt), 64'd4);

    // taken branch to 0x4
    drive(0, '0, 1, 64'h4, 0, 0);
    check("br_en", 64'(branch_en), 64'd1);
    check("br_pc", branch_pc, 64'h4); tick();
    check("br_fetch", tb_pc, 64'h4);
    idle();
    check("br_flush2", 64'(if_id_flush), 64'd1);
    check("br_en_once", 64'(branch_en), 64'd0); tick();
    idle(); check("br_flush_end", 64'(if_id_flush), 64'd0); tick();

    // branch beats same-cycle load-use
    drive(1, mk(T_LOAD, 5'd5, 5'd1, 5'd0), 0, '0, 0, 0); tick();
    drive(1, mk(T_RTYPE, 5'd9, 5'd5, 5'd6), 1, 64'h10, 0, 0);
    check("brlu_en", 64'(branch_en), 64'd1);
    check("brlu_stall", 64'(stall), 64'd0); tick();
    check("brlu_cnt", 64'(hazard_cnt), 64'd4);
    idle(); tick(); idle(); tick();

    // branch during memory busy is deferred until release
    drive(0, '0, 1, 64'h20, 1, 0);
    check("frz_stall0", 64'(stall), 64'd1);
    check("frz_ben0", 64'(branch_en), 64'd0); tick();
    for (int i = 1; i < 3; i++) begin
      drive(0, '0, 0, '0, 1, 0);
      check($sformatf("frz_stall%0d", i), 64'(stall), 64'd1); tick();
    end
    idle();
    check("frz_release_en", 64'(branch_en), 64'd1);
    check("frz_release_pc", branch_pc, 64'h20); tick();
    idle(); tick(); idle(); tick();

    // reset mid-flush with a pending branch
    drive(0, '0, 1, 64'h30, 0, 0); tick();
    drive(0, '0, 1, 64'h40, 1, 0); tick();
    drive(0, '0, 0, '0, 0, 1);
    check("rstm_ben", 64'(branch_en), 64'd0);
    check("rstm_flush", 64'(if_id_flush), 64'd0); tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("rstm_noreplay%0d", i), 64'(branch_en), 64'd0); tick();
    end
    check("rstm_cnt", 64'(hazard_cnt), 64'd0);

    // new branch while flushing restarts the flush window
    drive(0, '0, 1, 64'h50, 0, 0); tick();
    drive(0, '0, 1, 64'h60, 0, 0);
    check("restart_pc", branch_pc, 64'h60); tick();
    idle(); check("restart_flush", 64'(if_id_flush), 64'd1); tick();
    idle(); check("restart_end", 64'(if_id_flush), 64'd0); tick();

    // freeze inside flush window holds the remaining flush cycle
    drive(0, '0, 1, 64'h70, 0, 0); tick();
    drive(0, '0, 0, '0, 1, 0);
    check("ff_frz_flush", 64'(if_id_flush), 64'd0); tick();
    idle(); check("ff_resume", 64'(if_id_flush), 64'd1); tick();
    idle(); tick();

    // load-use held across a freeze fires on release
    drive(1, mk(T_LOAD, 5'd5, 5'd1, 5'd0), 0, '0, 0, 0); tick();
    drive(1, mk(T_RTYPE, 5'd9, 5'd5, 5'd6), 0, '0, 1, 0);
    check("lufrz_bub", 64'(id_ex_bubble), 64'd0); tick();
    drive(1, mk(T_RTYPE, 5'd9, 5'd5, 5'd6), 0, '0, 0, 0);
    check("lufrz_bub_rel", 64'(id_ex_bubble), 64'd1); tick();
    check("lufrz_cnt", 64'(hazard_cnt), 64'd1);
    idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Owns the fetch stage's `stall`, `branch_en` and `branch_pc` inputs.
- Drives IF/ID flush and ID/EX bubble-insert signals to the pipeline registers.
- Tracks a shadow of the ID→EX→MEM destination registers. From that shadow it detects load-use hazards, applies taken-branch redirects with flush, and freezes the pipeline while data memory is busy.

Parameters:
- XLEN, 64, width of the PC and branch target.
- FLUSH_CYCLES, 2, number of cycles `if_id_flush` is held after a redirect (1..7).
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_instr  in  32  instruction currently in decode.
- id_valid  in  1  id_instr holds a real instruction (0 = bubble).
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- ex_branch_target  in  XLEN  signed target for the taken branch.
- dmem_busy  in  1  data memory access not yet complete.
- stall  out  1  to fetch: hold PC; also hold IF/ID.
- branch_en  out  1  to fetch: load branch_pc on the next posedge.
- branch_pc  out  XLEN  redirect target.
- if_id_flush  out  1  zero the IF/ID register.
- id_ex_bubble  out  1  insert a NOP into ID/EX instead of id_instr.
- hazard_cnt  out  16  saturating count of load-use stall cycles (debug).

Behaviour:
- Reset (rst=1 at posedge):
  - state=RUN, shadow regs cleared, pending branch cleared, flush counter=0, hazard_cnt=0.
  - While rst=1, all outputs are 0.
- Decode of id_instr (all fields from package constants):
  - opc=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
  - rs1 used for OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - rs2 used for OPC_RTYPE, OPC_STORE, OPC_BRANCH.
  - Unknown opcodes use no sources.
- Shadow pipeline:
  - ex_ld/ex_rd capture (id_valid && opc==OPC_LOAD, rd) on each advancing posedge.
  - A bubble or flush captures ld=0.
  - ex_* moves into mem_* likewise.
  - On a freeze (dmem_busy), nothing moves.
- Load-use hazard:
  - Condition: ex_ld && ex_rd!=0 && id_valid && ex_rd matches a used source.
  - Response, combinationally in the same cycle: stall=1 and id_ex_bubble=1.
  - Exactly 1 stall cycle per hazard, because the bubble clears ex_ld.
- Branch redirect:
  - On ex_branch_taken=1 (not frozen): branch_en=1 and branch_pc=ex_branch_target, combinationally, for that single cycle.
  - Same cycle: if_id_flush=1 and id_ex_bubble=1.
  - Then FLUSH state holds if_id_flush=1 for FLUSH_CYCLES-1 further cycles.
- States and transitions:
  - RUN: no active hazard.
  - FLUSH: counter decrements each cycle; returns to RUN at 0.
  - FREEZE: while dmem_busy=1, stall=1, bubble=0, flush=0, branch_en=0, and shadow regs hold. Returns to the prior state when dmem_busy=0.
- Priority, highest first: rst > dmem_busy > branch > load-use.
  - Branch taken together with load-use: the branch wins, and the load-use stall is dropped because the younger instruction is flushed.
  - ex_branch_taken arriving while dmem_busy=1: latch target into pending. Assert branch_en on the first cycle with dmem_busy=0. A later taken branch before release overwrites pending.
  - ex_branch_taken during FLUSH: restart the counter to FLUSH_CYCLES-1 and issue a new redirect.
- hazard_cnt: +1 per load-use stall cycle; saturates at 16'hFFFF and never wraps.
- rst asserted mid-FLUSH or mid-FREEZE: pending branch is discarded and nothing is replayed.
- Register x0 never causes a hazard.

Decomposition:
- Package `riscv_pipe_pkg` holds:
  - opcode constants OPC_RTYPE=7'b0110011, OPC_ITYPE=7'b0010011, OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, OPC_BRANCH=7'b1100111 (team BEQ encoding);
  - state enum RUN/FLUSH/FREEZE;
  - field-slice constants.
- One sub-module, `instr_src_decode`: combinational, id_instr → rs1, rs2, rd, uses_rs1, uses_rs2, is_load.

Test Plan:
- LD x5 enters EX, then ADD x9,x5,x6 is in ID → stall=1 and id_ex_bubble=1 for exactly 1 cycle, hazard_cnt=1, and PC holds one cycle.
- LD x0 followed by ADD x9,x0,x6 → no stall; hazard_cnt stays 0.
- ex_branch_taken=1 with target 64'h4 → branch_en=1 for 1 cycle, branch_pc=4, if_id_flush high 2 cycles, fetch PC=4 next cycle.
- Same-cycle taken branch (target 0x10) plus load-use → branch_en=1, stall=0, hazard_cnt unchanged.
- dmem_busy high 3 cycles, with taken branch (target 0x20) in the first of them → stall=1 for 3 cycles, branch_en=0 throughout, then branch_en=1 with branch_pc=0x20 on cycle 4.
- rst pulsed mid-FLUSH with a pending branch → all outputs 0 next cycle and no redirect afterward.
